// File: rtl/hazard_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scheduler
// Purpose  : 5-stage MIPS pipeline sequencer with hazard handling, a halt/flush
//            sequence and a saturating stall-cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scheduler #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_dren,
    input  logic             mem_dwen,
    input  logic             mem_halt,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic [1:0]       ex_regsel,
    input  logic [4:0]       ex_wsel,
    input  logic [1:0]       ex_pcsrc,
    input  logic             ex_btaken,
    input  logic             dflush_done,
    output logic             pc_en,
    output logic [1:0]       pc_sel,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             dflush_req,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] c_PC_NORM  = 2'b00;
    localparam logic [1:0] c_PC_BRAN  = 2'b01;
    localparam logic [1:0] c_PC_JR    = 2'b10;
    localparam logic [1:0] c_PC_J     = 2'b11;
    localparam logic [1:0] c_RS_DLOAD = 2'b01;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_DWAIT  = 2'b01,
        ST_FLUSH  = 2'b10,
        ST_HALTED = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             w_dstall;
    logic             w_redir;
    logic             w_luse;
    logic             w_count;

    assign w_dstall = (mem_dren | mem_dwen) & ~dhit;
    assign w_redir  = (ex_pcsrc == c_PC_J) | (ex_pcsrc == c_PC_JR) |
                      ((ex_pcsrc == c_PC_BRAN) & ex_btaken);
    assign w_luse   = (ex_regsel == c_RS_DLOAD) && (ex_wsel != 5'd0) &&
                      ((id_rs == ex_wsel) || (id_uses_rt && (id_rt == ex_wsel)));

    always_comb begin
        state_d     = state_q;
        pc_en       = 1'b0;
        pc_sel      = c_PC_NORM;
        if_id_en    = 1'b0;
        id_ex_en    = 1'b0;
        ex_mem_en   = 1'b0;
        mem_wb_en   = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        dflush_req  = 1'b0;
        halt        = 1'b0;
        case (state_q)
            ST_RUN, ST_DWAIT: begin
                if (w_dstall) begin
                    state_d = ST_DWAIT;
                end else if (mem_halt) begin
                    // Only the halt itself retires; everything behind it stays put.
                    mem_wb_en = 1'b1;
                    state_d   = ST_FLUSH;
                end else begin
                    state_d   = ST_RUN;
                    id_ex_en  = 1'b1;
                    ex_mem_en = 1'b1;
                    mem_wb_en = 1'b1;
                    if (w_redir) begin
                        pc_en       = 1'b1;
                        pc_sel      = ex_pcsrc;
                        if_id_en    = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (w_luse) begin
                        id_ex_flush = 1'b1;
                    end else if (!ihit) begin
                        if_id_en    = 1'b1;
                        if_id_flush = 1'b1;
                    end else begin
                        pc_en    = 1'b1;
                        if_id_en = 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                dflush_req = 1'b1;
                if (dflush_done) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                halt = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        if (RST) begin
            state_d     = ST_RUN;
            pc_en       = 1'b0;
            pc_sel      = c_PC_NORM;
            if_id_en    = 1'b0;
            id_ex_en    = 1'b0;
            ex_mem_en   = 1'b0;
            mem_wb_en   = 1'b0;
            if_id_flush = 1'b0;
            id_ex_flush = 1'b0;
            dflush_req  = 1'b0;
            halt        = 1'b0;
        end
    end

    assign w_count = ((state_q == ST_RUN) || (state_q == ST_DWAIT)) && !pc_en &&
                     (cnt_q != {CNT_W{1'b1}});

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (w_count) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign stall_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scheduler
// Purpose  : Directed self-checking bench for hazard_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_scheduler;

    localparam int c_CNT_W = 4;

    // Control word order: pc_en, pc_sel[1:0], if_id/id_ex/ex_mem/mem_wb en,
    // if_id_flush, id_ex_flush, dflush_req, halt
    localparam logic [10:0] c_ZERO   = 11'b0_00_0000_00_0_0;
    localparam logic [10:0] c_NORMAL = 11'b1_00_1111_00_0_0;
    localparam logic [10:0] c_LUSE   = 11'b0_00_0111_01_0_0;
    localparam logic [10:0] c_NOIHIT = 11'b0_00_1111_10_0_0;
    localparam logic [10:0] c_BRAN   = 11'b1_01_1111_11_0_0;
    localparam logic [10:0] c_JR     = 11'b1_10_1111_11_0_0;
    localparam logic [10:0] c_J      = 11'b1_11_1111_11_0_0;
    localparam logic [10:0] c_HALTWB = 11'b0_00_0001_00_0_0;
    localparam logic [10:0] c_FLUSH  = 11'b0_00_0000_00_1_0;
    localparam logic [10:0] c_HALTED = 11'b0_00_0000_00_0_1;

    logic CLK = 1'b0;
    logic RST, ihit, dhit, mem_dren, mem_dwen, mem_halt, id_uses_rt, ex_btaken, dflush_done;
    logic [4:0] id_rs, id_rt, ex_wsel;
    logic [1:0] ex_regsel, ex_pcsrc;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush;
    logic dflush_req, halt;
    logic [1:0] pc_sel;
    logic [c_CNT_W-1:0] stall_cnt;
    logic [10:0] ctl;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    hazard_scheduler #(.CNT_W(c_CNT_W)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .mem_dren(mem_dren), .mem_dwen(mem_dwen), .mem_halt(mem_halt),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_regsel(ex_regsel), .ex_wsel(ex_wsel), .ex_pcsrc(ex_pcsrc),
        .ex_btaken(ex_btaken), .dflush_done(dflush_done),
        .pc_en(pc_en), .pc_sel(pc_sel), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .dflush_req(dflush_req), .halt(halt),
        .stall_cnt(stall_cnt)
    );

    assign ctl = {pc_en, pc_sel, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                  if_id_flush, id_ex_flush, dflush_req, halt};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check outputs mid-cycle, then advance past the next rising edge.
    task automatic cyc(input string tag, input logic [10:0] exp_ctl, input int exp_cnt);
        @(negedge CLK);
        chk({tag, "_ctl"}, {21'd0, ctl}, {21'd0, exp_ctl});
        if (exp_cnt >= 0) chk({tag, "_cnt"}, {28'd0, stall_cnt}, exp_cnt);
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        ihit = 1'b1; dhit = 1'b0; mem_dren = 1'b0; mem_dwen = 1'b0; mem_halt = 1'b0;
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; ex_regsel = 2'b00;
        ex_wsel = 5'd0; ex_pcsrc = 2'b00; ex_btaken = 1'b0; dflush_done = 1'b0;
    endtask

    initial begin
        idle_inputs();
        ihit = 1'b0;
        RST  = 1'b1;
        @(posedge CLK); #1;
        cyc("reset", c_ZERO, 0);

        RST = 1'b0; ihit = 1'b1;
        cyc("normal", c_NORMAL, 0);

        mem_dren = 1'b1;
        for (int i = 0; i < 3; i++) cyc("dwait_freeze", c_ZERO, i);
        dhit = 1'b1;
        cyc("dwait_release", c_NORMAL, 3);

        mem_dren = 1'b0; dhit = 1'b0; dflush_done = 1'b1;
        cyc("flushdone_ignored", c_NORMAL, 3);
        dflush_done = 1'b0;

        ex_regsel = 2'b01; ex_wsel = 5'd8; id_rs = 5'd8;
        cyc("luse_rs", c_LUSE, 3);
        id_rs = 5'd3; id_rt = 5'd8; id_uses_rt = 1'b1;
        cyc("luse_rt", c_LUSE, 4);
        id_uses_rt = 1'b0;
        cyc("rt_unused", c_NORMAL, 5);
        ex_wsel = 5'd0; id_rs = 5'd0;
        cyc("luse_r0", c_NORMAL, 5);

        ex_regsel = 2'b00; ex_pcsrc = 2'b01; ex_btaken = 1'b1; ihit = 1'b0;
        cyc("bran_taken", c_BRAN, 5);
        ex_btaken = 1'b0;
        cyc("bran_not_taken", c_NOIHIT, 5);
        ex_pcsrc = 2'b10; ihit = 1'b1;
        cyc("jr", c_JR, 6);
        ex_pcsrc = 2'b11; ex_regsel = 2'b01; ex_wsel = 5'd8; id_rs = 5'd8;
        cyc("j_over_luse", c_J, 6);

        idle_inputs();
        mem_dwen = 1'b1;
        for (int i = 0; i < 12; i++) cyc("sat_freeze", c_ZERO, (6 + i > 15) ? 15 : 6 + i);
        dhit = 1'b1; ihit = 1'b0;
        cyc("sat_release", c_NOIHIT, 15);
        chk("sat_hold_cnt", {28'd0, stall_cnt}, 32'd15);

        dhit = 1'b0; ihit = 1'b1; RST = 1'b1;
        cyc("rst_in_dwait", c_ZERO, -1);
        RST = 1'b0; mem_dwen = 1'b0;
        cyc("after_rst_dwait", c_NORMAL, 0);

        mem_halt = 1'b1;
        cyc("halt_wb", c_HALTWB, 0);
        mem_halt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dflush_done = (i == 3);
            cyc("flush", c_FLUSH, 1);
        end
        dflush_done = 1'b0; ex_pcsrc = 2'b11; mem_halt = 1'b1;
        for (int i = 0; i < 10; i++) cyc("halted", c_HALTED, 1);

        idle_inputs();
        RST = 1'b1;
        cyc("rst_from_halt", c_ZERO, -1);
        RST = 1'b0;
        cyc("run_after_halt", c_NORMAL, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
